crc5_token_arbiter: RTL



---
 rtl/usb_pkg.sv | 36 +++
 rtl/token_pkt_builder.sv | 60 ++++++
 rtl/crc5_token_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// ----------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the CRC5 token arbiter slice.
//   - Token PID constants (OUT, IN, SETUP, SOF)
//   - Arbiter state encoding arb_state_t
//   - make_token(): assembles the 19-bit packet handed to the CRC5 encoder
//   - is_token_pid(): true for PIDs the host transaction engine may send
// ----------------------------------------------------------------------------
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;

    localparam int PKT_W = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // Bit 0 goes on the wire first: PID, then its complement check nibble,
    // then the 11-bit payload.
    function automatic logic [PKT_W-1:0] make_token(input logic [3:0]  pid,
                                                   input logic [10:0] payload);
        return {payload, ~pid, pid};
    endfunction

    function automatic logic is_token_pid(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP);
    endfunction

endpackage

// File: rtl/token_pkt_builder.sv
// ----------------------------------------------------------------------------
// token_pkt_builder
// Packet capture register for the arbiter. On a granted request the 19-bit
// packet and its source flag are latched and held until the next grant, so
// the encoder sees a stable packet from START through BUSY.
//
// Ports
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_load_sof      capture an SOF packet from i_sof_frame this edge
//   i_load_tok      capture a token packet from the tok fields this edge
//   i_sof_frame     11-bit frame number
//   i_tok_pid       token PID
//   i_tok_addr      7-bit device address
//   i_tok_endp      4-bit endpoint number
//   o_pid_legal     combinational: i_tok_pid is OUT, IN or SETUP
//   o_pkt           captured packet
//   o_pkt_src       captured source, 1 = SOF, 0 = token
// ----------------------------------------------------------------------------
module token_pkt_builder
    import usb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_sof,
    input  logic              i_load_tok,
    input  logic [10:0]       i_sof_frame,
    input  logic [3:0]        i_tok_pid,
    input  logic [6:0]        i_tok_addr,
    input  logic [3:0]        i_tok_endp,
    output logic              o_pid_legal,
    output logic [PKT_W-1:0]  o_pkt,
    output logic              o_pkt_src
);

    logic [PKT_W-1:0] r_pkt;
    logic             r_pkt_src;
    logic [10:0]      w_tok_payload;

    assign w_tok_payload = {i_tok_endp, i_tok_addr};
    assign o_pid_legal   = is_token_pid(i_tok_pid);

    // The arbiter never raises both loads together (SOF has priority), but
    // SOF is still tested first so the register follows the same priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pkt     <= '0;
            r_pkt_src <= 1'b0;
        end else if (i_load_sof) begin
            r_pkt     <= make_token(PID_SOF, i_sof_frame);
            r_pkt_src <= 1'b1;
        end else if (i_load_tok) begin
            r_pkt     <= make_token(i_tok_pid, w_tok_payload);
            r_pkt_src <= 1'b0;
        end
    end

    assign o_pkt     = r_pkt;
    assign o_pkt_src = r_pkt_src;

endmodule

// File: rtl/crc5_token_arbiter.sv
// ----------------------------------------------------------------------------
// crc5_token_arbiter
// Arbitrates between the SOF frame timer and the host transaction engine,
// hands the assembled 19-bit packet to the CRC5 encoder with a one-cycle
// start, waits for the encoder's done (or a timeout), then holds off for an
// inter-packet gap before the next grant.
//
// Handshakes: a requester raises *_req and holds it (with its fields stable)
// until the matching *_ack, which is a one-cycle combinational grant issued
// in IDLE; fields are captured on the edge that ends the ack cycle. A request
// dropped before its ack is simply never granted. enc_start is a one-cycle
// load pulse; enc_done is a one-cycle pulse honoured only in BUSY.
//
// Parameters
//   GAP_CYCLES      idle cycles between done/timeout and next grant (1..255)
//   TIMEOUT_CYCLES  BUSY cycles allowed before abort (2..1023)
//
// Ports
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_sof_req/i_sof_frame   SOF request and frame number
//   o_sof_ack               SOF grant (same cycle as request seen in IDLE)
//   i_tok_req, i_tok_pid,
//   i_tok_addr, i_tok_endp  token request and fields
//   o_tok_ack               token grant (also pulsed for a dropped bad PID)
//   o_enc_pkt, o_enc_start  packet and load pulse to the encoder
//   i_enc_done              encoder completion pulse
//   o_pkt_done, o_pkt_src   completion pulse and its source (1=SOF)
//   o_pid_err               illegal token PID dropped
//   o_timeout_err           encoder timed out
//   o_busy                  state != IDLE
//   o_dbg_state             current FSM state
// ----------------------------------------------------------------------------
module crc5_token_arbiter
    import usb_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_sof_req,
    input  logic [10:0]       i_sof_frame,
    output logic              o_sof_ack,
    input  logic              i_tok_req,
    input  logic [3:0]        i_tok_pid,
    input  logic [6:0]        i_tok_addr,
    input  logic [3:0]        i_tok_endp,
    output logic              o_tok_ack,
    output logic [PKT_W-1:0]  o_enc_pkt,
    output logic              o_enc_start,
    input  logic              i_enc_done,
    output logic              o_pkt_done,
    output logic              o_pkt_src,
    output logic              o_pid_err,
    output logic              o_timeout_err,
    output logic              o_busy,
    output logic [1:0]        o_dbg_state
);

    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

    arb_state_t       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_gap_cnt;
    logic             r_enc_start;
    logic             r_busy;

    logic w_in_idle;
    logic w_in_busy;
    logic w_grant_sof;
    logic w_grant_tok;
    logic w_drop_tok;
    logic w_done;
    logic w_timeout;
    logic w_pid_legal;

    // Grants are Mealy outputs. Reset forces the state to IDLE, so the IDLE
    // decode is also gated by reset to keep every pulse low during reset.
    assign w_in_idle   = (r_state == IDLE) && !i_reset;
    assign w_in_busy   = (r_state == BUSY);
    assign w_grant_sof = w_in_idle && i_sof_req;
    assign w_grant_tok = w_in_idle && !i_sof_req && i_tok_req && w_pid_legal;
    assign w_drop_tok  = w_in_idle && !i_sof_req && i_tok_req && !w_pid_legal;

    // Done wins over the timeout limit when both land in the same cycle.
    assign w_done      = w_in_busy && i_enc_done;
    assign w_timeout   = w_in_busy && !i_enc_done && (r_timer == TMR_LAST);

    token_pkt_builder u_builder (
        .i_clk       (i_clock),
        .i_rst       (i_reset),
        .i_load_sof  (w_grant_sof),
        .i_load_tok  (w_grant_tok),
        .i_sof_frame (i_sof_frame),
        .i_tok_pid   (i_tok_pid),
        .i_tok_addr  (i_tok_addr),
        .i_tok_endp  (i_tok_endp),
        .o_pid_legal (w_pid_legal),
        .o_pkt       (o_enc_pkt),
        .o_pkt_src   (o_pkt_src)
    );

    // Both counters are cleared on entry to their state and stop at their
    // last value by leaving the state, so neither can wrap.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_gap_cnt   <= '0;
            r_enc_start <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_sof || w_grant_tok) begin
                        r_state     <= START;
                        r_enc_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                START: begin
                    r_state     <= BUSY;
                    r_timer     <= '0;
                    r_enc_start <= 1'b0;
                end
                BUSY: begin
                    if (w_done || w_timeout) begin
                        r_state   <= GAP;
                        r_gap_cnt <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_enc_start <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_sof_ack     = w_grant_sof;
    assign o_tok_ack     = w_grant_tok || w_drop_tok;
    assign o_pid_err     = w_drop_tok;
    assign o_pkt_done    = w_done;
    assign o_timeout_err = w_timeout;
    assign o_enc_start   = r_enc_start;
    assign o_busy        = r_busy;
    assign o_dbg_state   = r_state;

endmodule
